// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared control-bundle layout, bubble value and forwarding encodings
package ctrl_pipe_pkg;

  localparam int CTRL_W = 8;
  localparam int REG_AW = 5;

  // Bundle bit positions; the ID-stage decoder packs ctrl_i with these same indices.
  localparam int CB_REGWRITE = 7;
  localparam int CB_MEMTOREG = 6;
  localparam int CB_MEMREAD  = 5;
  localparam int CB_MEMWRITE = 4;
  localparam int CB_ALUSRC   = 3;
  localparam int CB_ALUOP_HI = 2;
  localparam int CB_ALUOP_LO = 1;
  localparam int CB_REGDST   = 0;

  localparam logic [CTRL_W-1:0] BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memread;
    logic              memwrite;
    logic [REG_AW-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] rd;
  } memwb_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - ID-stage inputs and per-stage control outputs of ctrl_pipe
interface ctrl_pipe_if import ctrl_pipe_pkg::*; ;

  logic [CTRL_W-1:0] ctrl_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              flush_i;
  logic              stall_o;
  logic              ex_alusrc_o;
  logic [1:0]        ex_aluop_o;
  logic [REG_AW-1:0] ex_rs_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              wb_regwrite_o;
  logic              wb_memtoreg_o;
  logic [REG_AW-1:0] wb_rd_o;

  modport master (
    output ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
    input  stall_o, ex_alusrc_o, ex_aluop_o, ex_rs_o, fwd_a_o, fwd_b_o,
           mem_read_o, mem_write_o, wb_regwrite_o, wb_memtoreg_o, wb_rd_o
  );

  modport slave (
    input  ctrl_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
    output stall_o, ex_alusrc_o, ex_aluop_o, ex_rs_o, fwd_a_o, fwd_b_o,
           mem_read_o, mem_write_o, wb_regwrite_o, wb_memtoreg_o, wb_rd_o
  );

endinterface

// File: rtl/ctrl_pipe_fwd_unit.sv
// rtl/ctrl_pipe_fwd_unit.sv - EX-stage operand forwarding selects (combinational)
module fwd_unit
  import ctrl_pipe_pkg::*;
(
  input  logic              exmem_regwrite_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              memwb_regwrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [REG_AW-1:0] idex_rs_i,
  input  logic [REG_AW-1:0] idex_rt_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  // The younger EX/MEM result wins; r0 is hardwired zero and is never a forwarding source.
  function automatic fwd_sel_e pick(input logic              em_we,
                                    input logic [REG_AW-1:0] em_rd,
                                    input logic              mw_we,
                                    input logic [REG_AW-1:0] mw_rd,
                                    input logic [REG_AW-1:0] src);
    if (em_we && (em_rd != '0) && (em_rd == src)) return FWD_EXMEM;
    if (mw_we && (mw_rd != '0) && (mw_rd == src)) return FWD_MEMWB;
    return FWD_NONE;
  endfunction

  always_comb begin
    fwd_a_o = pick(exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i, idex_rs_i);
    fwd_b_o = pick(exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i, idex_rt_i);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall and flush
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  ctrl_pipe_if.slave   bus
);

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   haz;

  always_comb begin
    haz = idex_q.ctrl[CB_MEMREAD] && (idex_q.rt != '0) &&
          ((idex_q.rt == bus.id_rs_i) || (idex_q.rt == bus.id_rt_i));

    // Addresses always advance; only the control bundle is squashed to a bubble.
    idex_d.ctrl = (haz || bus.flush_i) ? BUBBLE : bus.ctrl_i;
    idex_d.rs   = bus.id_rs_i;
    idex_d.rt   = bus.id_rt_i;
    idex_d.rd   = bus.id_rd_i;

    exmem_d.regwrite = idex_q.ctrl[CB_REGWRITE];
    exmem_d.memtoreg = idex_q.ctrl[CB_MEMTOREG];
    exmem_d.memread  = idex_q.ctrl[CB_MEMREAD];
    exmem_d.memwrite = idex_q.ctrl[CB_MEMWRITE];
    exmem_d.rd       = idex_q.ctrl[CB_REGDST] ? idex_q.rd : idex_q.rt;

    memwb_d.regwrite = exmem_q.regwrite;
    memwb_d.memtoreg = exmem_q.memtoreg;
    memwb_d.rd       = exmem_q.rd;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  fwd_unit u_fwd (
    .exmem_regwrite_i (exmem_q.regwrite),
    .exmem_rd_i       (exmem_q.rd),
    .memwb_regwrite_i (memwb_q.regwrite),
    .memwb_rd_i       (memwb_q.rd),
    .idex_rs_i        (idex_q.rs),
    .idex_rt_i        (idex_q.rt),
    .fwd_a_o          (bus.fwd_a_o),
    .fwd_b_o          (bus.fwd_b_o)
  );

  assign bus.stall_o       = haz && !bus.flush_i;
  assign bus.ex_alusrc_o   = idex_q.ctrl[CB_ALUSRC];
  assign bus.ex_aluop_o    = idex_q.ctrl[CB_ALUOP_HI:CB_ALUOP_LO];
  assign bus.ex_rs_o       = idex_q.rs;
  assign bus.mem_read_o    = exmem_q.memread;
  assign bus.mem_write_o   = exmem_q.memwrite;
  assign bus.wb_regwrite_o = memwb_q.regwrite;
  assign bus.wb_memtoreg_o = memwb_q.memtoreg;
  assign bus.wb_rd_o       = memwb_q.rd;

  // Write/read enables must never be unknown once they reach EX.
  a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_i)
    !$isunknown({idex_q.ctrl[CB_REGWRITE], idex_q.ctrl[CB_MEMREAD], idex_q.ctrl[CB_MEMWRITE]}));

endmodule
